// File: rtl/sha2_blk_asm.sv
`default_nettype none
// ============================================================================
// Module      : sha2_blk_asm
// Description : SHA-2 message block assembler. Packs big-endian message
//               packets into BW-bit blocks and appends the SHA-2 padding
//               (0x80 marker, zero fill, big-endian bit-length field),
//               spilling into an extra block when the length field does
//               not fit behind the marker.
// Ports       : clk       rising-edge clock
//               rst_b     asynchronous active-low reset
//               clr       synchronous clear, highest priority
//               pkt       message packet (byte 0 in the MSBs)
//               pkt_vld   packet valid
//               pkt_last  final packet of the message
//               pkt_nb    valid bytes in the final packet (0..NB, >NB = NB)
//               pkt_rdy   packet accepted this cycle when pkt_vld is high
//               blk       assembled block, slot k at blk[BW-1-k*PW -: PW]
//               blk_vld   blk holds a complete block
//               blk_rdy   consumer accepts blk
//               blk_last  blk is the final block of the message
// Revision    : 1.0 - initial release
// ============================================================================
module sha2_blk_asm #(
  parameter int PW = 64,   // packet width: 32 or 64
  parameter int BW = 512   // block width: 512 or 1024
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  clr,
  input  logic [PW-1:0]         pkt,
  input  logic                  pkt_vld,
  input  logic                  pkt_last,
  input  logic [$clog2(PW/8):0] pkt_nb,
  output logic                  pkt_rdy,
  output logic [BW-1:0]         blk,
  output logic                  blk_vld,
  input  logic                  blk_rdy,
  output logic                  blk_last
);

  localparam int NP  = BW / PW;          // packet slots per block
  localparam int LW  = BW / 8;           // length-field bits
  localparam int LP  = LW / PW;          // slots occupied by the length field
  localparam int NB  = PW / 8;           // bytes per packet
  localparam int NBW = $clog2(NB) + 1;   // width of pkt_nb
  localparam int IW  = $clog2(NP) + 1;   // slot index must be able to hold NP

  localparam logic [IW-1:0]  c_idx_len  = IW'(NP - LP);
  localparam logic [IW-1:0]  c_idx_top  = IW'(NP - 1);
  localparam logic [IW-1:0]  c_idx_full = IW'(NP);
  localparam logic [NBW-1:0] c_nb_full  = NBW'(NB);

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_PAD  = 3'd1,
    ST_ZERO = 3'd2,
    ST_LEN  = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  state_t          r_state;
  state_t          r_ret;      // where to go after the held block transfers
  logic [IW-1:0]   r_idx;
  logic [LW-1:0]   r_len;
  logic [BW-1:0]   r_blk;
  logic            r_last;

  state_t          w_state_nxt;
  state_t          w_ret_nxt;
  logic [IW-1:0]   w_idx_nxt;
  logic [LW-1:0]   w_len_nxt;
  logic            w_last_nxt;
  logic            w_wr_en;
  logic [PW-1:0]   w_wr_data;
  logic [NBW-1:0]  w_nb;
  logic [PW-1:0]   w_pkt_pad;
  logic [PW-1:0]   w_pad_word;
  logic [PW-1:0]   w_len_word;

  // Byte counts above NB behave as a full packet.
  assign w_nb = (pkt_nb > c_nb_full) ? c_nb_full : pkt_nb;

  // Final packet: keep the first w_nb bytes, put the 0x80 marker right
  // after them and zero the rest. With w_nb == NB this is the raw packet.
  always_comb begin
    w_pkt_pad = '0;
    for (int b = 0; b < NB; b++) begin
      if (NBW'(b) < w_nb) begin
        w_pkt_pad[PW-1-8*b -: 8] = pkt[PW-1-8*b -: 8];
      end else if (NBW'(b) == w_nb) begin
        w_pkt_pad[PW-1-8*b -: 8] = 8'h80;
      end
    end
  end

  always_comb begin
    w_pad_word            = '0;
    w_pad_word[PW-1 -: 8] = 8'h80;
  end

  // Length field is the last LP slots; pick the big-endian chunk that
  // belongs to the slot currently being written.
  always_comb begin
    w_len_word = '0;
    for (int j = 0; j < LP; j++) begin
      if (r_idx == IW'(NP - LP + j)) begin
        w_len_word = r_len[LW-1-j*PW -: PW];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_last_nxt  = r_last;
    w_wr_en     = 1'b0;
    w_wr_data   = '0;
    pkt_rdy     = 1'b0;
    blk_vld     = 1'b0;

    case (r_state)
      ST_LOAD: begin
        pkt_rdy = 1'b1;
        if (pkt_vld) begin
          w_wr_en   = 1'b1;
          w_idx_nxt = r_idx + IW'(1);
          if (pkt_last) begin
            w_wr_data = w_pkt_pad;
            if (w_nb == c_nb_full) begin
              w_len_nxt   = r_len + LW'(PW);
              w_state_nxt = ST_PAD;
            end else begin
              w_len_nxt   = r_len + LW'({w_nb, 3'b000});
              w_state_nxt = ST_ZERO;
            end
          end else begin
            w_wr_data = pkt;
            w_len_nxt = r_len + LW'(PW);
            if (r_idx == c_idx_top) begin
              w_state_nxt = ST_HOLD;
              w_ret_nxt   = ST_LOAD;
              w_last_nxt  = 1'b0;
            end
          end
        end
      end

      ST_PAD: begin
        // A full final packet can land in the top slot; the marker then
        // goes to slot 0 of the next block.
        if (r_idx == c_idx_full) begin
          w_state_nxt = ST_HOLD;
          w_ret_nxt   = ST_PAD;
          w_last_nxt  = 1'b0;
        end else begin
          w_wr_en     = 1'b1;
          w_wr_data   = w_pad_word;
          w_idx_nxt   = r_idx + IW'(1);
          w_state_nxt = ST_ZERO;
        end
      end

      ST_ZERO: begin
        if (r_idx == c_idx_len) begin
          w_state_nxt = ST_LEN;
        end else if (r_idx == c_idx_full) begin
          // Marker landed past the length field: flush this block and
          // continue zero-filling in the next one.
          w_state_nxt = ST_HOLD;
          w_ret_nxt   = ST_ZERO;
          w_last_nxt  = 1'b0;
        end else begin
          w_wr_en   = 1'b1;
          w_idx_nxt = r_idx + IW'(1);
        end
      end

      ST_LEN: begin
        w_wr_en   = 1'b1;
        w_wr_data = w_len_word;
        w_idx_nxt = r_idx + IW'(1);
        if (r_idx == c_idx_top) begin
          w_state_nxt = ST_HOLD;
          w_ret_nxt   = ST_LOAD;
          w_last_nxt  = 1'b1;
        end
      end

      ST_HOLD: begin
        blk_vld = 1'b1;
        if (blk_rdy) begin
          w_idx_nxt  = '0;
          w_last_nxt = 1'b0;
          if (r_last) begin
            w_len_nxt   = '0;
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = r_ret;
          end
        end
      end

      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_LOAD;
      r_ret   <= ST_LOAD;
    end else if (clr) begin
      r_state <= ST_LOAD;
      r_ret   <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_idx  <= '0;
      r_len  <= '0;
      r_last <= 1'b0;
      r_blk  <= '0;
    end else if (clr) begin
      r_idx  <= '0;
      r_len  <= '0;
      r_last <= 1'b0;
      r_blk  <= '0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_len  <= w_len_nxt;
      r_last <= w_last_nxt;
      for (int k = 0; k < NP; k++) begin
        if (w_wr_en && (r_idx == IW'(k))) begin
          r_blk[BW-1-k*PW -: PW] <= w_wr_data;
        end
      end
    end
  end

  assign blk      = r_blk;
  assign blk_last = r_last;

endmodule
`default_nettype wire

// File: tb/tb_sha2_blk_asm.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha2_blk_asm
// Description : Self-checking bench for sha2_blk_asm. Two instances share
//               the stimulus bus: a 512-bit block assembler and a 1024-bit
//               one, both with 64-bit packets; sel picks the active one.
//               Expected blocks come from a byte-level SHA-2 padding model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha2_blk_asm;

  logic        clk     = 1'b0;
  logic        rst_b   = 1'b0;
  logic        clr     = 1'b0;
  logic [63:0] pkt     = '0;
  logic        pkt_vld = 1'b0;
  logic        pkt_last = 1'b0;
  logic [3:0]  pkt_nb  = '0;
  logic        blk_rdy = 1'b0;
  logic        sel     = 1'b0;

  logic          vld0, vld1, rdy0, rdy1, bv0, bv1, bl0, bl1;
  logic [511:0]  blk0;
  logic [1023:0] blk1;
  logic          cur_rdy, cur_vld, cur_last;
  logic [1023:0] cur_blk;

  assign vld0     = pkt_vld & ~sel;
  assign vld1     = pkt_vld & sel;
  assign cur_rdy  = sel ? rdy1 : rdy0;
  assign cur_vld  = sel ? bv1 : bv0;
  assign cur_last = sel ? bl1 : bl0;
  assign cur_blk  = sel ? blk1 : {blk0, 512'h0};

  sha2_blk_asm #(.PW(64), .BW(512)) u_dut512 (
    .clk(clk), .rst_b(rst_b), .clr(clr), .pkt(pkt), .pkt_vld(vld0),
    .pkt_last(pkt_last), .pkt_nb(pkt_nb), .pkt_rdy(rdy0), .blk(blk0),
    .blk_vld(bv0), .blk_rdy(blk_rdy), .blk_last(bl0)
  );

  sha2_blk_asm #(.PW(64), .BW(1024)) u_dut1k (
    .clk(clk), .rst_b(rst_b), .clr(clr), .pkt(pkt), .pkt_vld(vld1),
    .pkt_last(pkt_last), .pkt_nb(pkt_nb), .pkt_rdy(rdy1), .blk(blk1),
    .blk_vld(bv1), .blk_rdy(blk_rdy), .blk_last(bl1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  byte unsigned  msg_q[$];
  byte unsigned  exp_q[$];
  logic [63:0]   pq[$];
  logic          lq[$];
  logic [3:0]    nq[$];
  logic [1023:0] got_q[$];

  function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
    for (int w = 0; w < 16; w++) begin
      if (a[1023-64*w -: 64] !== b[1023-64*w -: 64]) return w;
    end
    return 0;
  endfunction

  // SHA-2 padding on the byte stream: message, 0x80, zeros, bit length.
  task automatic build_model(input int bb);
    logic [127:0] bitlen;
    int lb;
    lb = bb / 8;
    exp_q = msg_q;
    exp_q.push_back(8'h80);
    while ((exp_q.size() % bb) != (bb - lb)) exp_q.push_back(8'h00);
    bitlen = 128'(msg_q.size()) * 128'd8;
    for (int i = 0; i < lb; i++) exp_q.push_back(bitlen[8*(lb-1-i) +: 8]);
  endtask

  // Split the message into 8-byte packets. With rnd set, an exact multiple
  // of 8 may end in an extra empty packet, and a full last packet may carry
  // an oversized byte count.
  task automatic build_pkts(input bit rnd);
    int L, nfull, r;
    bit extra;
    logic [63:0] w;
    L = msg_q.size();
    nfull = L / 8;
    r = L % 8;
    pq.delete(); lq.delete(); nq.delete();
    extra = (L == 0) || (r != 0) || (rnd && ($urandom_range(0, 1) == 1));
    for (int k = 0; k < nfull; k++) begin
      for (int b = 0; b < 8; b++) w[63-8*b -: 8] = msg_q[8*k+b];
      pq.push_back(w);
      if (k == nfull - 1 && !extra) begin
        lq.push_back(1'b1);
        nq.push_back(rnd ? 4'($urandom_range(8, 15)) : 4'd8);
      end else begin
        lq.push_back(1'b0);
        nq.push_back(4'($urandom_range(0, 15)));
      end
    end
    if (extra) begin
      w = {$urandom, $urandom};
      for (int b = 0; b < r; b++) w[63-8*b -: 8] = msg_q[8*nfull+b];
      pq.push_back(w);
      lq.push_back(1'b1);
      nq.push_back(4'(r));
    end
  endtask

  task automatic run_msg(input logic s, input int hold, input bit rnd);
    int pi, bi, cyc, held, nblk, bb, w;
    bit seen;
    logic [1023:0] eb, prev;
    pi = 0; bi = 0; cyc = 0; held = 0; seen = 0; prev = '0;
    bb = s ? 128 : 64;
    build_pkts(rnd);
    build_model(bb);
    nblk = exp_q.size() / bb;
    got_q.delete();
    sel = s;
    while (bi < nblk && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      blk_rdy  = 1'b0;
      pkt_vld  = 1'b0;
      pkt      = {$urandom, $urandom};
      pkt_last = 1'($urandom_range(0, 1));
      pkt_nb   = 4'($urandom_range(0, 15));
      if (cur_vld) begin
        if (!seen) begin
          eb = '0;
          for (int i = 0; i < bb; i++) eb[1023-8*i -: 8] = exp_q[bi*bb+i];
          checks++;
          if (cur_blk !== eb) begin
            failures++;
            w = first_diff(cur_blk, eb);
            $display("FAIL blk_data sel=%0d blk=%0d word=%0d got=%h exp=%h",
                     s, bi, w, cur_blk[1023-64*w -: 64], eb[1023-64*w -: 64]);
          end
          checks++;
          if (cur_last !== 1'(bi == nblk - 1)) begin
            failures++;
            $display("FAIL blk_last sel=%0d blk=%0d got=%b exp=%b", s, bi, cur_last, (bi == nblk - 1));
          end
          got_q.push_back(cur_blk);
          seen = 1;
          prev = cur_blk;
        end else begin
          checks++;
          if (cur_blk !== prev || cur_last !== 1'(bi == nblk - 1)) begin
            failures++;
            w = first_diff(cur_blk, prev);
            $display("FAIL hold_stable sel=%0d blk=%0d word=%0d got=%h exp=%h",
                     s, bi, w, cur_blk[1023-64*w -: 64], prev[1023-64*w -: 64]);
          end
        end
        checks++;
        if (cur_rdy !== 1'b0) begin
          failures++;
          $display("FAIL pkt_rdy_in_hold sel=%0d got=%b exp=0", s, cur_rdy);
        end
        if (held < hold) held++;
        else blk_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (blk_rdy) begin
          bi++;
          seen = 0;
          held = 0;
        end
      end else if (cur_rdy && pi < pq.size() && !(rnd && $urandom_range(0, 3) == 0)) begin
        pkt      = pq[pi];
        pkt_last = lq[pi];
        pkt_nb   = nq[pi];
        pkt_vld  = 1'b1;
        pi++;
      end
    end
    checks++;
    if (bi < nblk) begin
      failures++;
      $display("FAIL timeout sel=%0d blocks got=%0d exp=%0d", s, bi, nblk);
    end
    checks++;
    if (pi != pq.size()) begin
      failures++;
      $display("FAIL pkts_consumed sel=%0d got=%0d exp=%0d", s, pi, pq.size());
    end
    @(negedge clk);
    blk_rdy = 1'b0;
    pkt_vld = 1'b0;
  endtask

  // Push n non-final packets into the 512-bit instance.
  task automatic push_raw(input int n);
    int sent, cyc;
    sent = 0; cyc = 0;
    sel = 1'b0;
    blk_rdy = 1'b0;
    while (sent < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
      pkt_vld = 1'b0;
      if (rdy0) begin
        pkt = {$urandom, $urandom};
        pkt_last = 1'b0;
        pkt_vld = 1'b1;
        sent++;
      end
    end
    @(negedge clk);
    pkt_vld = 1'b0;
  endtask

  task automatic check_const(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    int w;
    checks++;
    if (got !== exp) begin
      failures++;
      w = first_diff(got, exp);
      $display("FAIL %s word=%0d got=%h exp=%h", name, w, got[1023-64*w -: 64], exp[1023-64*w -: 64]);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  task automatic test_reset();
    #12;
    check_bit("reset_rdy0", rdy0, 1'b1);
    check_bit("reset_vld0", bv0, 1'b0);
    check_bit("reset_last0", bl0, 1'b0);
    check_const("reset_blk0", {blk0, 512'h0}, '0);
    check_bit("reset_rdy1", rdy1, 1'b1);
    check_bit("reset_vld1", bv1, 1'b0);
    check_const("reset_blk1", blk1, '0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check_bit("post_reset_rdy0", rdy0, 1'b1);
  endtask

  task automatic test_empty();
    msg_q.delete();
    run_msg(1'b0, 0, 1'b0);
    check_const("empty_blk", got_q.size() > 0 ? got_q[0] : '0,
                {64'h8000000000000000, 448'h0, 512'h0});
  endtask

  task automatic test_abc();
    load_abc();
    run_msg(1'b0, 0, 1'b0);
    check_const("abc_blk", got_q.size() > 0 ? got_q[0] : '0,
                {64'h6162638000000000, 384'h0, 64'h18, 512'h0});
  endtask

  task automatic test_seven_full();
    msg_q.delete();
    for (int i = 0; i < 56; i++) msg_q.push_back(8'($urandom));
    run_msg(1'b0, 0, 1'b0);
    check_const("seven_b1_w7", {(got_q.size() > 0 ? got_q[0][575:512] : 64'h0), 960'h0},
                {64'h8000000000000000, 960'h0});
    check_const("seven_b2", got_q.size() > 1 ? got_q[1] : '0,
                {448'h0, 64'h1C0, 512'h0});
  endtask

  task automatic test_backpressure();
    load_abc();
    run_msg(1'b0, 5, 1'b0);
    check_bit("bp_vld_after", bv0, 1'b0);
    check_bit("bp_rdy_after", rdy0, 1'b1);
    check_const("bp_blk", got_q.size() > 0 ? got_q[0] : '0,
                {64'h6162638000000000, 384'h0, 64'h18, 512'h0});
  endtask

  task automatic test_clr_mid();
    push_raw(3);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_bit("clr_rdy", rdy0, 1'b1);
    check_const("clr_blk", {blk0, 512'h0}, '0);
    load_abc();
    run_msg(1'b0, 0, 1'b0);
    check_const("clr_abc_blk", got_q.size() > 0 ? got_q[0] : '0,
                {64'h6162638000000000, 384'h0, 64'h18, 512'h0});
  endtask

  task automatic test_clr_hold();
    push_raw(8);
    check_bit("full_hold_vld", bv0, 1'b1);
    check_bit("full_hold_last", bl0, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_bit("clr_hold_vld", bv0, 1'b0);
    check_bit("clr_hold_rdy", rdy0, 1'b1);
    check_const("clr_hold_blk", {blk0, 512'h0}, '0);
  endtask

  task automatic test_async_reset_mid();
    push_raw(2);
    #2;
    rst_b = 1'b0;
    #1;
    check_const("arst_blk", {blk0, 512'h0}, '0);
    check_bit("arst_rdy", rdy0, 1'b1);
    @(negedge clk);
    rst_b = 1'b1;
    load_abc();
    run_msg(1'b0, 0, 1'b0);
    check_const("arst_abc_blk", got_q.size() > 0 ? got_q[0] : '0,
                {64'h6162638000000000, 384'h0, 64'h18, 512'h0});
  endtask

  task automatic test_wide_abc();
    load_abc();
    run_msg(1'b1, 0, 1'b0);
    check_const("wide_abc_blk", got_q.size() > 0 ? got_q[0] : '0,
                {64'h6162638000000000, 896'h0, 64'h18});
  endtask

  task automatic test_random();
    for (int m = 0; m < 40; m++) begin
      msg_q.delete();
      for (int i = 0, n = $urandom_range(0, 150); i < n; i++) msg_q.push_back(8'($urandom));
      run_msg(1'(m % 2), 0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_seven_full();
    test_backpressure();
    test_clr_mid();
    test_clr_hold();
    test_async_reset_mid();
    test_wide_abc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
